fetch_mem_ctrl: RTL and testbench
=================================

Name: fetch_mem_ctrl

Overview:
- Sequences the single-port, synchronous-read instruction memory that feeds the fetch stage.
- Owns the boot phase: a program loader writes instruction words while the core is held in reset via `start=0`.
- Owns the run phase: issues one read per fetch PC, inserts wait states and drives `stall_f` until the word returns.
- Squashes in-flight reads on a branch redirect (`redirect` = PCSrcE).

Parameters:
WAIT_STATES, 1, extra memory read-latency cycles beyond the first; legal range 0..15
ADDR_W, 32, width of loader and memory addresses

Ports:
clk  in  1  core clock; all state changes on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
load_req  in  1  loader write request (BOOT only)
load_addr  in  ADDR_W  loader byte address
load_data  in  32  loader instruction word
load_done  in  1  loader finished; leave BOOT
load_ack  out  1  write accepted this cycle
pc_f  in  32  current fetch PC
redirect  in  1  taken branch/jump resolved in Execute
start  out  1  core run enable
stall_f  out  1  hold PC and the fetch/decode register
instr_f  out  32  fetched instruction; 32'h00000013 (NOP) when instr_valid=0
instr_valid  out  1  instr_f is valid for pc_f this cycle
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data; valid WAIT_STATES+1 cycles after the mem_en read cycle

Behaviour:
- Reset (async, rst=0), taking effect immediately, including mid-read:
  - state=BOOT, start=0, stall_f=1, instr_valid=0, instr_f=NOP.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, load_ack=0.
  - Wait counter=0, squash flag=0.
- State BOOT:
  - load_req=1 → combinationally drive mem_en=1, mem_we=1, mem_addr=load_addr, mem_wdata=load_data, load_ack=1 (single-cycle write).
  - load_done=1 → ISSUE next cycle. If load_req is also 1 that cycle, the write is still performed.
  - start=0 and stall_f=1 throughout BOOT.
- State ISSUE (run phase, start=1 from here onward):
  - Drive mem_en=1, mem_we=0, mem_addr=pc_f; load counter with WAIT_STATES; go to WAIT.
  - stall_f=1, unless redirect=1. In that case stall_f=0 (PC loads the target), no read is committed, and the state stays ISSUE.
- State WAIT:
  - mem_en=0; counter decrements each cycle.
  - When counter==0 (response cycle), mem_rdata is valid:
    - Squash=0 and redirect=0: instr_valid=1, instr_f=mem_rdata, stall_f=0 (PC and fetch/decode register advance); go to ISSUE.
    - Squash=1 or redirect=1: instr_valid=0, instr_f=NOP, clear squash; go to ISSUE. stall_f=0 only if redirect=1 this cycle, otherwise 1.
  - redirect=1 before the response cycle: set squash, stall_f=0 for that cycle (PC takes target), keep counting.
- Throughput: one instruction per WAIT_STATES+2 cycles (WAIT_STATES=0 → every 2 cycles).
- In ISSUE/WAIT, load_req and load_done are ignored and load_ack=0. The only way back to BOOT is reset.
- Outputs mem_* and load_ack are combinational from state and inputs; state, counter and squash are registered.
- With WAIT_STATES=0, WAIT lasts exactly one cycle and that cycle is the response cycle.

Test Plan:
- Reset mid-WAIT (WAIT_STATES=3): assert rst=0 → start=0, stall_f=1, instr_valid=0, instr_f=32'h00000013 immediately; after rst=1 the block is in BOOT and mem_en=0.
- Boot load: write 0x00500093 @0x0 and 0x00A00113 @0x4 with load_req, then load_done.
  - load_ack=1 each write cycle, with mem_we=1 and the matching mem_addr/mem_wdata.
  - start rises the cycle after load_done.
  - load_req asserted after boot gives load_ack=0.
- Steady fetch, WAIT_STATES=1, pc_f=0 → mem_en at cycle T; instr_valid=1 with instr_f=0x00500093 and stall_f=0 at T+2; next mem_en at T+3 with pc_f=4.
- Redirect in WAIT: WAIT_STATES=2, redirect=1 one cycle after issue → stall_f=0 that cycle; response cycle shows instr_valid=0, instr_f=NOP; next ISSUE uses the new pc_f.
- Redirect coincident with response cycle → instr_valid=0, stall_f=0, then re-issue at the target address.
- WAIT_STATES=0 sweep over 8 sequential PCs → instr_valid pulses every 2nd cycle; no instr_valid during BOOT; load_done+load_req in the same cycle still writes the word.

Source files
------------

// File: rtl/fetch_mem_ctrl_if.sv
// Instruction memory bus between fetch_mem_ctrl (master) and the memory (slave).
// Ports: mem_en/mem_we/mem_addr/mem_wdata to memory, mem_rdata back.
interface fetch_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/fetch_mem_ctrl.sv
// Instruction memory sequencer: boot-time loader writes, then one read per PC.
// Ports: clk, rst (async low), loader bus, pc_f/redirect, fetch outputs, mem bus.
module fetch_mem_ctrl #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              load_done,
  output logic              load_ack,
  input  logic [31:0]       pc_f,
  input  logic              redirect,
  output logic              start,
  output logic              stall_f,
  output logic [31:0]       instr_f,
  output logic              instr_valid,
  fetch_mem_ctrl_if.master  mem
);

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [3:0]  WS  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    BOOT,
    ISSUE,
    WAIT
  } state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       squash, squash_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= BOOT;
      cnt    <= '0;
      squash <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      squash <= squash_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    squash_n      = squash;
    start         = 1'b0;
    stall_f       = 1'b1;
    instr_f       = NOP;
    instr_valid   = 1'b0;
    load_ack      = 1'b0;
    mem.mem_en    = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;

    unique case (state)
      BOOT: begin
        // rst gates the write so nothing reaches memory while held in reset
        if (load_req && rst) begin
          load_ack      = 1'b1;
          mem.mem_en    = 1'b1;
          mem.mem_we    = 1'b1;
          mem.mem_addr  = load_addr;
          mem.mem_wdata = load_data;
        end
        if (load_done) begin
          state_n = ISSUE;
        end
      end

      ISSUE: begin
        start = 1'b1;
        if (redirect) begin
          // PC takes the target; issue from it next cycle
          stall_f = 1'b0;
        end else begin
          mem.mem_en   = 1'b1;
          mem.mem_addr = ADDR_W'(pc_f);
          cnt_n        = WS;
          state_n      = WAIT;
        end
      end

      WAIT: begin
        start = 1'b1;
        if (cnt == 4'd0) begin
          state_n  = ISSUE;
          squash_n = 1'b0;
          if (!squash && !redirect) begin
            instr_valid = 1'b1;
            instr_f     = mem.mem_rdata;
            stall_f     = 1'b0;
          end else begin
            stall_f = !redirect;
          end
        end else begin
          cnt_n = cnt - 4'd1;
          if (redirect) begin
            // word in flight belongs to the old path
            squash_n = 1'b1;
            stall_f  = 1'b0;
          end
        end
      end

      default: begin
        state_n = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_mem_ctrl.sv
// Bench: four controllers (WAIT_STATES 0..3) on shared stimulus, each
// checked every cycle against a timestamp-based fetch model.
module tb_fetch_mem_ctrl;

  localparam int          N   = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic        load_done;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        redirect;
  logic [31:0] pc_f [N];

  logic        load_ack    [N];
  logic        start       [N];
  logic        stall_f     [N];
  logic        instr_valid [N];
  logic [31:0] instr_f     [N];
  logic        men         [N];
  logic        mwe         [N];
  logic [31:0] maddr       [N];
  logic [31:0] mwd         [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : gi
    fetch_mem_ctrl_if #(.ADDR_W(32)) bus ();

    fetch_mem_ctrl #(
      .WAIT_STATES(g),
      .ADDR_W(32)
    ) dut (
      .clk(clk),
      .rst(rst),
      .load_req(load_req),
      .load_addr(load_addr),
      .load_data(load_data),
      .load_done(load_done),
      .load_ack(load_ack[g]),
      .pc_f(pc_f[g]),
      .redirect(redirect),
      .start(start[g]),
      .stall_f(stall_f[g]),
      .instr_f(instr_f[g]),
      .instr_valid(instr_valid[g]),
      .mem(bus.master)
    );

    assign men[g]   = bus.mem_en;
    assign mwe[g]   = bus.mem_we;
    assign maddr[g] = bus.mem_addr;
    assign mwd[g]   = bus.mem_wdata;

    // memory: data only visible exactly g+1 cycles after the read strobe
    logic [31:0] mem [16];
    logic [31:0] pd  [g+1];
    logic        pv  [g+1];

    always_ff @(posedge clk) begin
      if (bus.mem_en && bus.mem_we)
        mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k <= g; k++) pv[k] <= 1'b0;
      end else begin
        pv[0] <= bus.mem_en && !bus.mem_we;
        pd[0] <= mem[bus.mem_addr[5:2]];
        for (int k = 1; k <= g; k++) begin
          pv[k] <= pv[k-1];
          pd[k] <= pd[k-1];
        end
      end
    end

    assign bus.mem_rdata = pv[g] ? pd[g] : 32'hDEADBEEF;
  end

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          run    [N];
  bit          busy   [N];
  bit          sq     [N];
  int          t_resp [N];
  logic [31:0] ipc    [N];
  logic [31:0] pcm    [N];
  logic [31:0] img    [16];
  int          cyc;

  task automatic chk(input string tag, input int i,
                     input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s[ws=%0d] cyc=%0d got=%h want=%h", tag, i, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      run[i]    = 0;
      busy[i]   = 0;
      sq[i]     = 0;
      t_resp[i] = 0;
      ipc[i]    = '0;
      pcm[i]    = '0;
    end
  endtask

  // one clock: drive at posedge+1, check at posedge+3, advance model
  task automatic step(input logic lr, input logic ld,
                      input logic [31:0] la, input logic [31:0] ldat,
                      input logic rd, input logic [31:0] tgt);
    bit          n_run [N];
    bit          n_busy[N];
    bit          n_sq  [N];
    logic [31:0] n_pc  [N];
    logic [31:0] e_ins, e_addr, e_wd;
    logic        e_ack, e_en, e_we, e_start, e_stall, e_val;
    load_req  = lr;
    load_done = ld;
    load_addr = la;
    load_data = ldat;
    redirect  = rd;
    for (int i = 0; i < N; i++) pc_f[i] = pcm[i];
    #2;
    for (int i = 0; i < N; i++) begin
      e_ack = 0; e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
      e_start = run[i]; e_stall = 1; e_val = 0; e_ins = NOP;
      n_run[i] = run[i]; n_busy[i] = busy[i]; n_sq[i] = sq[i];
      n_pc[i] = pcm[i];
      if (!run[i]) begin
        if (lr) begin
          e_ack = 1; e_en = 1; e_we = 1; e_addr = la; e_wd = ldat;
        end
        if (ld) n_run[i] = 1;
      end else if (!busy[i]) begin
        if (rd) e_stall = 0;
        else begin
          e_en = 1;
          e_addr = pcm[i];
          n_busy[i] = 1;
          t_resp[i] = cyc + i + 1;
          ipc[i] = pcm[i];
        end
      end else if (cyc == t_resp[i]) begin
        n_busy[i] = 0;
        n_sq[i] = 0;
        if (!sq[i] && !rd) begin
          e_val = 1;
          e_ins = img[ipc[i][5:2]];
          e_stall = 0;
        end else e_stall = !rd;
      end else if (rd) begin
        n_sq[i] = 1;
        e_stall = 0;
      end
      if (!e_stall) n_pc[i] = rd ? tgt : pcm[i] + 32'd4;
      chk("load_ack", i, 32'(load_ack[i]), 32'(e_ack));
      chk("mem_en", i, 32'(men[i]), 32'(e_en));
      chk("mem_we", i, 32'(mwe[i]), 32'(e_we));
      chk("mem_addr", i, maddr[i], e_addr);
      chk("mem_wdata", i, mwd[i], e_wd);
      chk("start", i, 32'(start[i]), 32'(e_start));
      chk("stall_f", i, 32'(stall_f[i]), 32'(e_stall));
      chk("instr_valid", i, 32'(instr_valid[i]), 32'(e_val));
      chk("instr_f", i, instr_f[i], e_ins);
    end
    if (!run[0] && lr) img[la[5:2]] = ldat;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      run[i] = n_run[i]; busy[i] = n_busy[i]; sq[i] = n_sq[i];
      pcm[i] = n_pc[i];
    end
    cyc++;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_start"}, i, 32'(start[i]), 32'd0);
      chk({tag, "_stall"}, i, 32'(stall_f[i]), 32'd1);
      chk({tag, "_valid"}, i, 32'(instr_valid[i]), 32'd0);
      chk({tag, "_instr"}, i, instr_f[i], NOP);
      chk({tag, "_en"}, i, 32'(men[i]), 32'd0);
      chk({tag, "_we"}, i, 32'(mwe[i]), 32'd0);
      chk({tag, "_addr"}, i, maddr[i], 32'd0);
      chk({tag, "_wdata"}, i, mwd[i], 32'd0);
      chk({tag, "_ack"}, i, 32'(load_ack[i]), 32'd0);
    end
  endtask

  task automatic boot(input bit fixed);
    logic [31:0] w;
    for (int k = 0; k < 16; k++) begin
      w = $urandom;
      if (fixed && k == 0) w = 32'h00500093;
      if (fixed && k == 1) w = 32'h00A00113;
      // last word is written in the same cycle as load_done
      step(1'b1, k == 15, 32'(k * 4), w, 1'b0, 32'd0);
    end
  endtask

  task automatic run_phase(input int n, input int quiet);
    logic        rd, lr;
    logic [31:0] tgt;
    for (int c = 0; c < n; c++) begin
      rd  = (c >= quiet) && ($urandom_range(0, 5) == 0);
      lr  = ($urandom_range(0, 3) == 0);
      tgt = 32'($urandom_range(0, 15)) << 2;
      step(lr, $urandom_range(0, 1) == 1, $urandom, $urandom, rd, tgt);
    end
  endtask

  initial begin
    int guard;
    cyc = 0;
    rst = 1'b0;
    load_req = 0; load_done = 0; load_addr = '0; load_data = '0;
    redirect = 0;
    for (int i = 0; i < N; i++) pc_f[i] = '0;
    for (int k = 0; k < 16; k++) img[k] = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b1;

    boot(1'b1);
    run_phase(250, 30);

    // bring the WAIT_STATES=3 unit into a pre-response wait cycle
    guard = 0;
    while (!(busy[3] && cyc < t_resp[3]) && guard < 20) begin
      step(1'b0, 1'b0, '0, '0, 1'b0, '0);
      guard++;
    end
    chk("reach_wait", 3, 32'(guard < 20), 32'd1);

    load_req = 1; load_addr = 32'h1C; load_data = 32'h12345678;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    load_req = 0;
    @(posedge clk);
    #1;
    check_reset_outputs("inrst");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // idle cycles in BOOT, then a fresh program
    step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    boot(1'b0);
    run_phase(300, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
